// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply/divide unit with HI/LO result registers.
// Define MUL_DIV_UNIT_DIV_EN to compile in the divider (DIVU/DIV); without it divide ops are ignored.
//
// state | meaning
// IDLE  | waiting for start; direct HI/LO writes accepted
// RUN   | one shift-add or restoring-divide step per cycle, wide cycles
// DONE  | HI/LO just loaded; done pulses for this single cycle
module mul_div_unit #(
  parameter int wide = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [wide-1:0] a,
  input  logic [wide-1:0] b,
  input  logic            we_hi,
  input  logic            we_lo,
  input  logic [wide-1:0] wd,
  output logic            busy,
  output logic            done,
  output logic [wide-1:0] hi,
  output logic [wide-1:0] lo
);

  localparam int cw = $clog2(wide);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [cw-1:0]     cnt;
  logic [wide-1:0]   acc_hi, acc_lo, mb_q;
  logic              neg_q;
  logic              accept, last;
  logic              a_neg, b_neg;
  logic [wide-1:0]   a_mag, b_mag;
  logic [wide:0]     mul_sum;
  logic [wide-1:0]   step_hi, step_lo;
  logic [2*wide-1:0] result;

`ifdef MUL_DIV_UNIT_DIV_EN
  logic              is_div_q, rneg_q, div_zero_q;
  logic [wide-1:0]   a_q;
  logic [wide:0]     div_shift, div_trial;

  assign accept = start && (state == IDLE);
`else
  assign accept = start && (state == IDLE) && !op[1];
`endif

  assign last  = (cnt == '0);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  // Both datapaths work on magnitudes; signs are reapplied when the result is loaded.
  assign a_neg = op[0] & a[wide-1];
  assign b_neg = op[0] & b[wide-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // acc_lo holds the multiplier (or dividend) and shifts out one bit per step.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mb_q} : '0);

  always_comb begin
    step_hi = mul_sum[wide:1];
    step_lo = {mul_sum[0], acc_lo[wide-1:1]};
`ifdef MUL_DIV_UNIT_DIV_EN
    div_shift = {acc_hi, acc_lo[wide-1]};
    div_trial = div_shift - {1'b0, mb_q};
    if (is_div_q) begin
      if (!div_trial[wide]) begin
        step_hi = div_trial[wide-1:0];
        step_lo = {acc_lo[wide-2:0], 1'b1};
      end else begin
        step_hi = div_shift[wide-1:0];
        step_lo = {acc_lo[wide-2:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    result = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
`ifdef MUL_DIV_UNIT_DIV_EN
    if (is_div_q) begin
      result[wide-1:0]      = neg_q  ? -step_lo : step_lo;
      result[2*wide-1:wide] = rneg_q ? -step_hi : step_hi;
      if (div_zero_q)
        result = {a_q, {wide{1'b1}}};
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mb_q   <= '0;
      neg_q  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt    <= cw'(wide - 1);
        acc_hi <= '0;
        acc_lo <= a_mag;
        mb_q   <= b_mag;
        neg_q  <= a_neg ^ b_neg;
      end else if (state == IDLE) begin
        if (we_hi) hi <= wd;
        if (we_lo) lo <= wd;
      end else if (state == RUN) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        cnt    <= cnt - cw'(1);
        if (last) {hi, lo} <= result;
      end
    end
  end

`ifdef MUL_DIV_UNIT_DIV_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_div_q   <= 1'b0;
      rneg_q     <= 1'b0;
      div_zero_q <= 1'b0;
      a_q        <= '0;
    end else if (accept) begin
      is_div_q   <= op[1];
      rneg_q     <= a_neg;
      div_zero_q <= (b == '0);
      a_q        <= a;
    end
  end
`endif

endmodule
